// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the ticket vending controller.
// Coin codes, credit states and fare values are fixed here.
package vending_machine_pkg;

   typedef enum logic [1:0] {
      S0  = 2'b00,
      S5  = 2'b01,
      S10 = 2'b10
   } vm_state_t;

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_5    = 2'd1;
   localparam logic [1:0] COIN_10   = 2'd2;
   localparam logic [1:0] COIN_BAD  = 2'd3;

   localparam logic [4:0] FARE       = 5'd15;
   localparam logic [4:0] COIN5_VAL  = 5'd5;
   localparam logic [4:0] COIN10_VAL = 5'd10;

   function automatic logic [4:0] credit_of(input vm_state_t s);
      logic [4:0] c;
      c = 5'd0;
      case (s)
         S5:      c = COIN5_VAL;
         S10:     c = COIN10_VAL;
         default: c = 5'd0;
      endcase
      return c;
   endfunction

   // Only the two real coins carry value; none and invalid codes add nothing.
   function automatic logic [4:0] coin_value(input logic [1:0] code);
      logic [4:0] v;
      v = 5'd0;
      case (code)
         COIN_5:  v = COIN5_VAL;
         COIN_10: v = COIN10_VAL;
         default: v = 5'd0;
      endcase
      return v;
   endfunction

   function automatic vm_state_t state_of(input logic [4:0] credit);
      vm_state_t s;
      s = S0;
      if (credit == COIN5_VAL) begin
         s = S5;
      end else if (credit == COIN10_VAL) begin
         s = S10;
      end
      return s;
   endfunction

endpackage

// File: rtl/vending_machine.sv
// Moore credit FSM with a registered one-cycle ticket pulse.
// Define VM_CREDIT_CARRY_EN to keep the 5-unit excess of a 20-unit payment.
module vending_machine
   import vending_machine_pkg::*;
(
   output logic       ticket,
   input  logic [1:0] coin,
   input  logic       clk,
   input  logic       rst
);

   vm_state_t  state;
   vm_state_t  state_d;
   logic       ticket_q;
   logic       ticket_d;
   logic [4:0] sum;

   always_comb begin
      state_d  = state;
      ticket_d = 1'b0;
      sum      = credit_of(state) + coin_value(coin);
      case (state)
         S0, S5, S10: begin
            if (coin == COIN_5 || coin == COIN_10) begin
               if (sum >= FARE) begin
                  ticket_d = 1'b1;
`ifdef VM_CREDIT_CARRY_EN
                  state_d  = state_of(sum - FARE);
`else
                  state_d  = S0;
`endif
               end else begin
                  state_d = state_of(sum);
               end
            end
         end
         // Unused encoding: fall back to empty credit without dispensing.
         default: begin
            state_d  = S0;
            ticket_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S0;
         ticket_q <= 1'b0;
      end else begin
         state    <= state_d;
         ticket_q <= ticket_d;
      end
   end

   assign ticket = ticket_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed scoreboard bench for vending_machine; expected state/ticket come
// from a transition-table model and are queued when each coin is driven.
module tb_vending_machine;

   logic       clk;
   logic       rst;
   logic [1:0] coin;
   logic       ticket;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] st;
      logic       tk;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] m_st;

   vending_machine dut (
      .ticket (ticket),
      .coin   (coin),
      .clk    (clk),
      .rst    (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_now(input string tag, input logic [1:0] exp_st, input logic exp_tk);
      checks++;
      assert (dut.state === exp_st) else begin
         errors++;
         $error("FAIL %s state got %b want %b", tag, dut.state, exp_st);
      end
      checks++;
      assert (ticket === exp_tk) else begin
         errors++;
         $error("FAIL %s ticket got %b want %b", tag, ticket, exp_tk);
      end
   endtask

   // Reference transitions written as an explicit table.
   task automatic model(input logic [1:0] c, output exp_t e);
      e.tk = 1'b0;
      e.st = m_st;
      case (m_st)
         2'b00: if (c == 2'd1) e.st = 2'b01; else if (c == 2'd2) e.st = 2'b10;
         2'b01: if (c == 2'd1) e.st = 2'b10;
                else if (c == 2'd2) begin e.st = 2'b00; e.tk = 1'b1; end
         2'b10: if (c == 2'd1) begin e.st = 2'b00; e.tk = 1'b1; end
                else if (c == 2'd2) begin
`ifdef VM_CREDIT_CARRY_EN
                   e.st = 2'b01;
`else
                   e.st = 2'b00;
`endif
                   e.tk = 1'b1;
                end
         default: e.st = 2'b00;
      endcase
      m_st = e.st;
   endtask

   task automatic step(input string tag, input logic [1:0] c);
      exp_t e;
      exp_t got;
      coin = c;
      model(c, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check_now(tag, got.st, got.tk);
      $display("coin=%0d state=%b ticket=%b exp_state=%b exp_ticket=%b [%s]",
               c, dut.state, ticket, got.st, got.tk, tag);
   endtask

   initial begin
      rst  = 1'b0;
      coin = 2'd0;
      m_st = 2'b00;
      #1;
      check_now("reset_initial", 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         coin = (i % 2 == 0) ? 2'd2 : 2'd0;
         @(posedge clk);
         #1;
         check_now("reset_hold", 2'b00, 1'b0);
      end
      @(negedge clk);
      rst  = 1'b1;
      coin = 2'd0;

      step("seq102_a", 2'd1);
      step("seq102_b", 2'd0);
      step("seq102_c", 2'd2);
      step("seq21_a", 2'd2);
      step("seq21_b", 2'd1);
      step("idle_after_pulse", 2'd0);
      step("seq111_a", 2'd1);
      step("seq111_b", 2'd1);
      step("seq111_c", 2'd1);
      step("seq201_a", 2'd2);
      step("seq201_hold", 2'd0);
      step("seq201_c", 2'd1);
      step("seq22_a", 2'd2);
      step("seq22_b", 2'd2);
      step("seq22_follow", 2'd2);
      step("settle", 2'd0);
      if (m_st != 2'b10) step("to_s10", 2'd2);
      if (m_st != 2'b10) step("to_s10_b", 2'd2);
      step("s10_bad_coin", 2'd3);
      step("s10_bad_coin2", 2'd3);

      @(negedge clk);
      rst  = 1'b0;
      coin = 2'd1;
      #1;
      check_now("async_reset", 2'b00, 1'b0);
      m_st = 2'b00;
      @(posedge clk);
      #1;
      check_now("reset_swallows_coin", 2'b00, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step("post_reset_coin5", 2'd1);
      step("post_reset_coin10", 2'd2);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain left %0d want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vending_machine.md
# vending_machine

Synchronous ticket vending controller that accepts 5- and 10-unit coins, accumulates credit, and pulses `ticket` when the 15-unit fare is reached. Sits between the coin-acceptor front end, which delivers one coded coin per clock, and the ticket dispenser actuator. The design is a single Moore FSM with a registered output.

## Interface
- No parameters. Fare and coin values are fixed constants in the package.
- `clk` input 1: system clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Low clears state and output immediately.
- `ticket` output 1: dispense pulse, registered, one cycle per fare completed.
- `coin` input 2: coin code sampled every rising edge.
  - 0 = no coin
  - 1 = 5 units
  - 2 = 10 units
  - 3 = invalid
- Port order: `ticket`, `coin`, `clk`, `rst`.

## Operation
- Internal 2-bit register `state` holds accumulated credit. Hierarchical name `state` is required because benches probe it.
  - S0 = 2'b00 (0 units)
  - S5 = 2'b01 (5 units)
  - S10 = 2'b10 (10 units)
  - 2'b11 is unused.
- Transitions per rising edge, with the ticket value registered on that same edge:
  - S0: coin 1 → S5; coin 2 → S10; ticket 0.
  - S5: coin 1 → S10, ticket 0; coin 2 → S0, ticket 1.
  - S10: coin 1 → S0, ticket 1.
  - S10, coin 2 (20 units): ticket 1. Next state is S5 with `VM_CREDIT_CARRY_EN` defined, else S0.
  - coin 0 or 3, any state: state held, ticket 0. Invalid coins are swallowed and add no credit.
  - State 2'b11, any coin: → S0, ticket 0 (recovery).
- `ticket` is high for exactly one cycle per completing edge. Back-to-back completions give consecutive high cycles.
- Reset values: `state` = S0, `ticket` = 0.
- Coin arrival and reset assertion together: reset wins and the coin is lost.

## Timing
- Latency: `ticket` rises on the same rising edge that samples the fare-completing coin. It is visible for that whole following cycle and drops on the next edge unless another fare completes.
- No handshake. A coin code present at an edge counts once. A code held for N edges counts N times.
- `rst` deassertion is asynchronous to `clk`. The first sampling edge after release operates from S0.
- Outputs are glitch-free. `ticket` is driven directly from a flop.

## Configuration
- `VM_CREDIT_CARRY_EN` defined: a 20-unit overpayment from S10 dispenses and keeps the 5-unit excess (next state S5).
- `VM_CREDIT_CARRY_EN` undefined (default): the excess is forfeited (next state S0).
- All other behaviour is identical in both builds.

## Structure
- Shared package `vending_machine_pkg` holds:
  - state enum `vm_state_t` (S0/S5/S10, 2 bits)
  - coin codes `COIN_NONE` / `COIN_5` / `COIN_10` / `COIN_BAD`
  - constants `FARE` = 15, `COIN5_VAL` = 5, `COIN10_VAL` = 10
- Single module. The next-state/output logic is one combinational block feeding one async-reset register block. No sub-module is warranted.

## Test plan
Clock period 10, `rst` low then released before the first coin, one coin code per cycle.
- Reset: hold `rst` low with coin 2 toggling → `state` = 00 and `ticket` = 0 throughout; first edge after release starts from S0.
- Sequence 1,0,2 → `state` 01, 01, 00; `ticket` = 1 only after the coin-2 edge.
- Sequence 2,1 → `state` 10 then 00; one-cycle `ticket` pulse.
- Sequences 1,1,1, then 2,0,1 → one ticket after the third coin; one ticket after the final coin-1; coin 0 holds `state` at 10.
- Sequence 2,2 → `ticket` pulse.
  - Default build: `state` 00.
  - `VM_CREDIT_CARRY_EN` build: `state` 01, and a following coin 2 produces a second ticket.
- Mid-operation and invalid input:
  - In S10, apply coin 3 → no change.
  - Assert `rst` low mid-cycle while in S10 → `state` 00 immediately; a subsequent coin 1 gives S5 with no ticket.
